// File: rtl/fx2bf_conv.sv
// fx2bf_conv
//   Signed fixed-point (Q INT_W.FRC_W) to bfloat-style float converter.
//   A word is accepted over a valid/ready handshake, normalised one bit per
//   cycle, rounded to nearest-even and held as sign/exponent/fraction with
//   zero and inexact flags until the consumer takes it. One conversion is in
//   flight at a time.
//
// Ports
//   clk          in   1      clock, rising edge
//   rst          in   1      asynchronous reset, active-high
//   in_valid_i   in   1      fix_i valid
//   in_ready_o   out  1      converter can accept (IDLE only)
//   fix_i        in   N      two's-complement input, value = fix_i / 2^FRC_W
//   out_valid_o  out  1      result valid, held until out_ready_i
//   out_ready_i  in   1      downstream accepts result
//   sgn_o        out  1      result sign
//   exp_o        out  EXP_W  biased exponent
//   fract_o      out  MAN_W  rounded stored fraction (hidden 1 dropped)
//   zero_o       out  1      input was exactly zero
//   inexact_o    out  1      rounding discarded nonzero bits
module fx2bf_conv #(
  parameter int INT_W = 8,
  parameter int FRC_W = 8,
  parameter int EXP_W = 8,
  parameter int MAN_W = 7,
  parameter int BIAS  = 127
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [INT_W+FRC_W-1:0]   fix_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic                     sgn_o,
  output logic [EXP_W-1:0]         exp_o,
  output logic [MAN_W-1:0]         fract_o,
  output logic                     zero_o,
  output logic                     inexact_o
);

  localparam int N     = INT_W + FRC_W;
  localparam int PW    = $clog2(N);
  localparam int GRD_W = N - 1 - MAN_W;  // bits below the stored fraction

  // Legal parameter space has no denormal or overflow path.
  if (N < MAN_W + 1) begin : g_chk_n
    $error("fx2bf_conv: INT_W+FRC_W must be at least MAN_W+1");
  end
  if (BIAS - FRC_W < 1) begin : g_chk_lo
    $error("fx2bf_conv: BIAS-FRC_W must be at least 1");
  end
  if (BIAS + INT_W > (1 << EXP_W) - 2) begin : g_chk_hi
    $error("fx2bf_conv: BIAS+INT_W exceeds largest normal exponent");
  end

  typedef enum logic [1:0] {IDLE, NORM, ROUND, HOLD} state_t;

  state_t               state_q, state_d;
  logic [N-1:0]         mag_q;
  logic [PW-1:0]        pos_q;
  logic                 sgn_q;

  logic                 sgn_in;
  logic [N-1:0]         mag_in;
  logic [MAN_W-1:0]     mant;
  logic                 guard;
  logic                 sticky;
  logic [EXP_W-1:0]     exp_pre;
  logic [EXP_W+MAN_W:0] rnd_res;

  // Round-to-nearest-even; returns {inexact, exponent, fraction}. A carry out
  // of an all-ones mantissa renormalises by bumping the exponent.
  function automatic logic [EXP_W+MAN_W:0] round_ne(
    input logic [MAN_W-1:0] m,
    input logic             g,
    input logic             s,
    input logic [EXP_W-1:0] e
  );
    logic             up;
    logic [EXP_W-1:0] eo;
    logic [MAN_W-1:0] fo;
    up = g & (s | m[0]);
    if (up && (&m)) begin
      fo = '0;
      eo = e + EXP_W'(1);
    end else begin
      fo = m + MAN_W'(up);
      eo = e;
    end
    return {g | s, eo, fo};
  endfunction

  // Magnitude as N-bit unsigned; the most-negative input maps to 2^(N-1).
  assign sgn_in = fix_i[N-1];
  assign mag_in = sgn_in ? (~fix_i + N'(1)) : fix_i;

  assign mant    = mag_q[N-2 -: MAN_W];
  assign exp_pre = EXP_W'(pos_q) + EXP_W'(BIAS - FRC_W);
  assign rnd_res = round_ne(mant, guard, sticky, exp_pre);

  if (GRD_W == 0) begin : g_gs_none
    assign guard  = 1'b0;
    assign sticky = 1'b0;
  end else if (GRD_W == 1) begin : g_gs_guard
    assign guard  = mag_q[0];
    assign sticky = 1'b0;
  end else begin : g_gs_full
    assign guard  = mag_q[GRD_W-1];
    assign sticky = |mag_q[GRD_W-2:0];
  end

  assign in_ready_o = (state_q == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid_i) state_d = (mag_in == '0) ? HOLD : NORM;
      NORM:    if (mag_q[N-1]) state_d = ROUND;
      ROUND:   state_d = HOLD;
      HOLD:    if (out_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mag_q       <= '0;
      pos_q       <= '0;
      sgn_q       <= 1'b0;
      out_valid_o <= 1'b0;
      sgn_o       <= 1'b0;
      exp_o       <= '0;
      fract_o     <= '0;
      zero_o      <= 1'b0;
      inexact_o   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid_i) begin
          mag_q <= mag_in;
          pos_q <= PW'(N - 1);
          sgn_q <= sgn_in;
          // Exact zero bypasses normalisation straight to the result.
          if (mag_in == '0) begin
            out_valid_o <= 1'b1;
            sgn_o       <= 1'b0;
            exp_o       <= '0;
            fract_o     <= '0;
            zero_o      <= 1'b1;
            inexact_o   <= 1'b0;
          end
        end
        NORM: if (!mag_q[N-1]) begin
          mag_q <= mag_q << 1;
          pos_q <= pos_q - PW'(1);
        end
        ROUND: begin
          out_valid_o <= 1'b1;
          sgn_o       <= sgn_q;
          {inexact_o, exp_o, fract_o} <= rnd_res;
          zero_o      <= 1'b0;
        end
        HOLD: if (out_ready_i) out_valid_o <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fx2bf_conv.sv
module tb_fx2bf_conv;

  localparam int INT_W = 8;
  localparam int FRC_W = 8;
  localparam int EXP_W = 8;
  localparam int MAN_W = 7;
  localparam int BIAS  = 127;
  localparam int N     = INT_W + FRC_W;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid_i = 1'b0;
  logic             in_ready_o;
  logic [N-1:0]     fix_i = '0;
  logic             out_valid_o;
  logic             out_ready_i = 1'b0;
  logic             sgn_o;
  logic [EXP_W-1:0] exp_o;
  logic [MAN_W-1:0] fract_o;
  logic             zero_o;
  logic             inexact_o;

  fx2bf_conv #(.INT_W(INT_W), .FRC_W(FRC_W), .EXP_W(EXP_W), .MAN_W(MAN_W), .BIAS(BIAS)) dut (
    .clk(clk), .rst(rst), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .fix_i(fix_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .sgn_o(sgn_o), .exp_o(exp_o),
    .fract_o(fract_o), .zero_o(zero_o), .inexact_o(inexact_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] fix;
    logic         sgn;
    int           ex;
    int           fr;
    logic         zero;
    logic         inx;
    int           lat;
    int           acc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   bp_hold = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: value-level arithmetic on the real magnitude.
  function automatic exp_t model(input logic [N-1:0] f);
    exp_t   r;
    longint v, mag, full, qq, rem, unit;
    int     p;
    r.fix = f;
    v = longint'($signed(f));
    r.acc = 0;
    if (v == 0) begin
      r.sgn = 0; r.ex = 0; r.fr = 0; r.zero = 1; r.inx = 0; r.lat = 0;
      return r;
    end
    r.sgn = (v < 0);
    mag = (v < 0) ? -v : v;
    p = 0;
    for (int i = 0; i < N; i++) if (mag >= (longint'(1) << i)) p = i;
    full = mag << MAN_W;
    unit = longint'(1) << p;
    qq   = full >> p;
    rem  = full - (qq << p);
    if ((2 * rem > unit) || ((2 * rem == unit) && (qq % 2 == 1))) qq++;
    r.ex = p - FRC_W + BIAS;
    if (qq == (longint'(1) << (MAN_W + 1))) begin
      qq = qq >> 1;
      r.ex++;
    end
    r.fr   = int'(qq - (longint'(1) << MAN_W));
    r.zero = 0;
    r.inx  = (rem != 0);
    r.lat  = (N - 1 - p) + 2;
    return r;
  endfunction

  task automatic issue(input logic [N-1:0] f, input bit push);
    exp_t e;
    int   w = 0;
    @(negedge clk);
    while (!in_ready_o && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready_o) begin
      chk("in_ready_timeout", 0, 1);
      return;
    end
    in_valid_i = 1'b1;
    fix_i = f;
    e = model(f);
    e.acc = cyc + 1;
    if (push) q.push_back(e);
    @(negedge clk);
    in_valid_i = 1'b0;
    fix_i = N'($urandom);
  endtask

  task automatic wait_drain();
    int w = 0;
    while (q.size() != 0 && w < 3000) begin
      @(negedge clk);
      w++;
    end
    chk("drain_pending", q.size(), 0);
  endtask

  // Sink: random backpressure, or held low on request.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready_i = bp_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor / scoreboard.
  initial begin
    bit   prev = 1'b0;
    int   first = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = 1'b0;
      end else begin
        if (out_valid_o && !prev) first = cyc;
        if (out_valid_o && out_ready_i) begin
          if (q.size() == 0) begin
            chk("unexpected_result", 1, 0);
          end else begin
            e = q.pop_front();
            chk($sformatf("sgn[%h]", e.fix), sgn_o, e.sgn);
            chk($sformatf("exp[%h]", e.fix), exp_o, e.ex);
            chk($sformatf("fract[%h]", e.fix), fract_o, e.fr);
            chk($sformatf("zero[%h]", e.fix), zero_o, e.zero);
            chk($sformatf("inexact[%h]", e.fix), inexact_o, e.inx);
            chk($sformatf("latency[%h]", e.fix), first - e.acc, e.lat);
          end
        end
        prev = out_valid_o;
      end
    end
  end

  logic [N-1:0] dir_vec [8];

  initial begin
    exp_t e;
    int   w;
    dir_vec[0] = 16'h0100; dir_vec[1] = 16'hFF00; dir_vec[2] = 16'h8000; dir_vec[3] = 16'h0000;
    dir_vec[4] = 16'h0181; dir_vec[5] = 16'h0183; dir_vec[6] = 16'h0003; dir_vec[7] = 16'h01FF;

    #1;
    chk("rst_in_ready", in_ready_o, 1);
    chk("rst_out_valid", out_valid_o, 0);
    chk("rst_outputs", {sgn_o, exp_o, fract_o, zero_o, inexact_o}, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    foreach (dir_vec[i]) issue(dir_vec[i], 1'b1);
    wait_drain();

    // Reset mid-normalisation (last result 0x01FF left exp 0x80 on outputs).
    issue(16'h0001, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", in_ready_o, 1);
    chk("midrst_out_valid", out_valid_o, 0);
    chk("midrst_outputs", {sgn_o, exp_o, fract_o, zero_o, inexact_o}, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("midrst_no_result", out_valid_o, 0);

    // Backpressure: hold consumer off for 5 cycles.
    bp_hold = 1'b1;
    e = model(16'h0183);
    issue(16'h0183, 1'b1);
    w = 0;
    while (!out_valid_o && w < 100) begin
      @(negedge clk);
      w++;
    end
    for (int k = 0; k < 5; k++) begin
      chk("bp_out_valid", out_valid_o, 1);
      chk("bp_in_ready", in_ready_o, 0);
      chk("bp_exp", exp_o, e.ex);
      chk("bp_fract", fract_o, e.fr);
      chk("bp_inexact", inexact_o, e.inx);
      @(negedge clk);
    end
    bp_hold = 1'b0;
    wait_drain();

    // Randomised conversions, with occasional zero, extremes and idle gaps.
    for (int n = 0; n < 300; n++) begin
      logic [N-1:0] f;
      case ($urandom_range(0, 9))
        0:       f = '0;
        1:       f = {1'b1, {(N-1){1'b0}}};
        2:       f = N'(1) << $urandom_range(0, N - 1);
        3:       f = N'($urandom_range(0, 15));
        default: f = N'($urandom);
      endcase
      issue(f, 1'b1);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
